quant_zigzag: RTL and testbench
===============================

# quant_zigzag

Downstream neighbour of the 8x8 DCT stage in the JPEG encoder pipeline. Accepts 64 signed 16-bit DCT coefficients per block in raster order (row v, column u, index = v*8+u). Quantizes each coefficient with a reciprocal-multiply against the standard luminance table and saturates the result. Emits the block in zigzag order to the entropy-coding stage, using a ping-pong buffer so one block can fill while the other drains.

## Interface
- SAT_MAX, default 2047: symmetric saturation bound; output is clamped to [-SAT_MAX, +SAT_MAX].
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  16  signed DCT coefficient, raster order.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  frame-end marker; meaningful on index 63 only.
- s_axis_tuser  in  1  frame-start marker; meaningful on index 0.
- m_axis_tdata  out  16  signed quantized coefficient, zigzag order.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on zigzag position 63 when the block's latched tlast was set.
- m_axis_tuser  out  1  high on zigzag position 0 when the block's latched tuser was set.

## Operation
- Storage: two banks of 64 x 16-bit registers, each with a full flag and a latched tuser/tlast bit.
- Write side:
  - Index counter wr_idx runs 0..63; wr_bank is the bank being filled.
  - s_axis_tready = !full[wr_bank] (combinational from registered flags).
- Pipeline:
  - Stage 1 registers the coefficient, wr_idx and wr_bank on each accepted beat.
  - Stage 2 computes the quantized value and writes it to the bank carried through the pipe.
- Quantize arithmetic:
  - mag = |c|, computed as a 17-bit unsigned magnitude so -32768 is handled.
  - R = RECIP[idx] = round(65536/Q[idx]), 16-bit unsigned.
  - q = (mag*R + rnd) >> 16, with a 33-bit product.
  - q is clamped to SAT_MAX, then the sign of c is reapplied.
  - Zero input gives zero output and never -0.
- End of block: the beat accepted at wr_idx 63 toggles wr_bank and resets wr_idx to 0. Stage 2 sets full[bank] on the same cycle it writes index 63.
- Resync: tuser high on an accepted beat with wr_idx != 0 discards the partial block. That beat is written as index 0 of the same bank.
- Read side FSM:
  - R_IDLE: waits for full[rd_bank].
  - R_OUT: loads m_axis_tdata from bank[rd_bank][ZIGZAG[rd_pos]] whenever !m_axis_tvalid || m_axis_tready.
  - The handshake at rd_pos 63 clears full[rd_bank], toggles rd_bank and goes to R_IDLE. If the other bank is already full, it stays in R_OUT with no bubble.
- tdata, tlast and tuser hold stable while tvalid && !tready.

## Timing
- Reset values:
  - s_axis_tready 1.
  - m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, m_axis_tuser 0.
  - All full flags 0, counters 0, both bank pointers 0, FSM R_IDLE.
- Latency: 64th input accepted at edge N; full set at edge N+1; first output valid after edge N+2.
- Throughput: 1 coefficient/cycle sustained in each direction.
- Both banks full: s_axis_tready low until the drain of rd_bank completes. It rises the cycle after the 64th output handshake.
- Simultaneous events: a full-set on one bank and a full-clear on the other in the same cycle are both honoured.
- Reset mid-operation: all in-flight data is lost and every output returns to its reset value immediately (asynchronous).

## Configuration
- QZ_ROUND_EN defined: rnd = 32768, i.e. round half away from zero.
- QZ_ROUND_EN undefined: rnd = 0, i.e. truncation toward zero.
- Every other behaviour and the timing are identical in both builds.

## Structure
- Package jpeg_qz_pkg holds:
  - ZIGZAG[64] (zigzag position to raster index, 6-bit);
  - QLUMA[64] (standard JPEG luminance table, 8-bit);
  - RECIP[64] (16-bit reciprocals);
  - the read FSM state typedef.
- Sub-module qz_mul: the stage-2 sign/multiply/round/saturate datapath, registered output, one cycle.

## Test plan
- Index 0 input 40 (Q=16), then -40 -> output 3 and -3 with QZ_ROUND_EN; 2 and -2 without.
- Raster index i input Q[i]*(i+1), QZ_ROUND_EN -> outputs 1, 2, 9, 17, 10, 3, 4, 11 ..., 64 (zigzag of raster index + 1).
- Index 0 inputs 32767 and -32768 -> outputs 2047 and -2047.
- Two back-to-back blocks with m_axis_tready low for 10 cycles mid-drain of block 0:
  - s_axis_tready falls after block 1 is full and rises the cycle after block 0's 64th handshake;
  - all 128 outputs are correct, with no loss or duplication.
- tuser on beat 0 and tlast on beat 63 -> m_axis_tuser on output 0 only and m_axis_tlast on output 63 only. Also, tuser at beat 20 -> the earlier 20 beats are discarded and the block restarts.
- rst_n asserted at beat 30 of a fill and during a drain -> all outputs reset at once; a subsequent clean block yields correct output after the 2-cycle latency.

Source files
------------

// File: rtl/jpeg_qz_pkg.sv
// Shared tables for the quantize/zigzag stage: zigzag scan order, JPEG luminance
// quantizer and its 16-bit reciprocals, plus the read-side FSM state type.
package jpeg_qz_pkg;

    // Zigzag position -> raster index (v*8+u).
    localparam logic [0:63][5:0] ZIGZAG = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    // Standard JPEG luminance quantization table, raster order.
    localparam logic [0:63][7:0] QLUMA = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    function automatic logic [0:63][15:0] calc_recip();
        logic [0:63][15:0] r;
        for (int i = 0; i < 64; i++) begin
            r[i] = 16'((32'd65536 + 32'(QLUMA[i] >> 1)) / 32'(QLUMA[i]));
        end
        return r;
    endfunction

    // round(65536 / Q) per raster index; smallest Q is 10, so every entry fits 16 bits.
    localparam logic [0:63][15:0] RECIP = calc_recip();

    typedef enum logic {
        R_IDLE = 1'b0,
        R_OUT  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/qz_mul.sv
// Sign/magnitude reciprocal-multiply quantizer with symmetric saturation, registered output.
// QZ_ROUND_EN defined: round half away from zero; undefined: truncate toward zero.
module qz_mul #(
    parameter int SAT_MAX = 2047
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] coef,
    input  logic [15:0] recip,
    output logic [15:0] q
);

`ifdef QZ_ROUND_EN
    localparam logic [32:0] RND = 33'd32768;
`else
    localparam logic [32:0] RND = 33'd0;
`endif
    localparam logic [16:0] SAT_LIM = 17'(SAT_MAX);

    logic        neg;
    logic [16:0] mag;
    logic [32:0] prod;
    logic [16:0] qmag;
    logic [15:0] qsat;
    logic [15:0] res;

    always_comb begin
        neg  = coef[15];
        // 17-bit magnitude so that -32768 becomes +32768 rather than wrapping.
        mag  = neg ? (~{1'b1, coef} + 17'd1) : {1'b0, coef};
        prod = {16'd0, mag} * {17'd0, recip};
        qmag = 17'((prod + RND) >> 16);
        qsat = (qmag > SAT_LIM) ? SAT_LIM[15:0] : qmag[15:0];
        res  = neg ? (16'd0 - qsat) : qsat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= res;
        end
    end

endmodule

// File: rtl/quant_zigzag.sv
// Quantizes raster-order 8x8 DCT blocks and re-emits them in zigzag order through
// two ping-pong banks. Rounding mode is selected by QZ_ROUND_EN (see qz_mul).
module quant_zigzag
    import jpeg_qz_pkg::*;
#(
    parameter int SAT_MAX = 2047
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser
);

    logic [5:0]  wr_idx;
    logic [5:0]  eff_idx;
    logic        wr_bank;
    logic        accept;
    logic        st_valid;
    logic [5:0]  st_idx;
    logic        st_bank;
    logic        st_user;
    logic        st_last;
    logic [15:0] q;
    logic [15:0] mem [0:1][0:63];
    logic [1:0]  full;
    logic [1:0]  user_lat;
    logic [1:0]  last_lat;
    logic [1:0]  set_mask;
    logic [1:0]  clr_mask;
    rd_state_t   state;
    rd_state_t   state_next;
    logic        rd_bank;
    logic [6:0]  rd_pos;
    logic        hs;
    logic        load;
    logic        finish;
    logic        load_bank;
    logic [5:0]  load_pos;

    assign s_axis_tready = !full[wr_bank];
    assign accept        = s_axis_tvalid && s_axis_tready;
    // A frame-start mid-block drops the partial block and restarts at index 0.
    assign eff_idx       = s_axis_tuser ? 6'd0 : wr_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx   <= '0;
            wr_bank  <= 1'b0;
            st_valid <= 1'b0;
            st_idx   <= '0;
            st_bank  <= 1'b0;
            st_user  <= 1'b0;
            st_last  <= 1'b0;
        end else begin
            st_valid <= accept;
            if (accept) begin
                st_idx  <= eff_idx;
                st_bank <= wr_bank;
                st_user <= s_axis_tuser;
                st_last <= s_axis_tlast;
                if (eff_idx == 6'd63) begin
                    wr_idx  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_idx <= eff_idx + 6'd1;
                end
            end
        end
    end

    qz_mul #(.SAT_MAX(SAT_MAX)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .coef  (s_axis_tdata),
        .recip (RECIP[eff_idx]),
        .q     (q)
    );

    always_ff @(posedge clk) begin
        if (st_valid) begin
            mem[st_bank][st_idx] <= q;
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (st_valid && st_idx == 6'd63) set_mask[st_bank] = 1'b1;
        if (finish) clr_mask[rd_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= '0;
            user_lat <= '0;
            last_lat <= '0;
        end else begin
            full <= (full & ~clr_mask) | set_mask;
            if (st_valid && st_idx == 6'd0)  user_lat[st_bank] <= st_user;
            if (st_valid && st_idx == 6'd63) last_lat[st_bank] <= st_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= R_IDLE;
        else        state <= state_next;
    end

    // rd_pos is the next zigzag position to load; 64 means position 63 is on the bus.
    always_comb begin
        hs         = m_axis_tvalid && m_axis_tready;
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            R_IDLE: begin
                if (full[rd_bank]) begin
                    load       = 1'b1;
                    state_next = R_OUT;
                end
            end
            R_OUT: begin
                if (hs && rd_pos == 7'd64) begin
                    finish = 1'b1;
                    if (full[!rd_bank]) load = 1'b1;
                    else                state_next = R_IDLE;
                end else if ((!m_axis_tvalid || m_axis_tready) && rd_pos != 7'd64) begin
                    load = 1'b1;
                end
            end
            default: state_next = R_IDLE;
        endcase
        load_bank = finish ? !rd_bank : rd_bank;
        load_pos  = finish ? 6'd0 : rd_pos[5:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            rd_pos        <= '0;
            rd_bank       <= 1'b0;
        end else begin
            if (load) begin
                m_axis_tdata  <= mem[load_bank][ZIGZAG[load_pos]];
                m_axis_tvalid <= 1'b1;
                m_axis_tuser  <= (load_pos == 6'd0) && user_lat[load_bank];
                m_axis_tlast  <= (load_pos == 6'd63) && last_lat[load_bank];
                rd_pos        <= {1'b0, load_pos} + 7'd1;
            end else if (finish) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tuser  <= 1'b0;
                m_axis_tlast  <= 1'b0;
                rd_pos        <= '0;
            end
            if (finish) rd_bank <= !rd_bank;
        end
    end

endmodule

// File: tb/tb_quant_zigzag.sv
// Bench for quant_zigzag: directed and random blocks checked against a reference model
// that quantizes with plain integer arithmetic and walks the zigzag diagonals.
module tb_quant_zigzag;

    localparam int SAT = 2047;
`ifdef QZ_ROUND_EN
    localparam longint RND = 32768;
`else
    localparam longint RND = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;

    quant_zigzag #(.SAT_MAX(SAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    // ---------------- reference model / scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [17:0] exp_q[$];
    int qtab[64] = '{16, 11, 10, 16, 24, 40, 51, 61, 12, 12, 14, 19, 26, 58, 60, 55,
                     14, 13, 16, 24, 40, 57, 69, 56, 14, 17, 22, 29, 51, 87, 80, 62,
                     18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
                     49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
    int recip[64];
    int zz[64];
    logic [15:0] blk[64];
    logic        blk_user;
    logic        blk_last;
    int          m_idx = 0;
    logic [15:0] stim[64];

    function automatic logic [15:0] ref_quant(input logic [15:0] c, input int r);
        int v;
        longint mag;
        longint qv;
        v   = int'($signed(c));
        mag = (v < 0) ? -v : v;
        qv  = (mag * recip[r] + RND) / 65536;
        if (qv > SAT) qv = SAT;
        if (v < 0) qv = -qv;
        return 16'(qv);
    endfunction

    task automatic build_tables();
        int p = 0;
        for (int i = 0; i < 64; i++) recip[i] = (65536 + qtab[i] / 2) / qtab[i];
        // Walk anti-diagonals u+v=s, alternating direction.
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) for (int v = hi; v >= lo; v--) begin zz[p] = v * 8 + (s - v); p++; end
            else            for (int v = lo; v <= hi; v++) begin zz[p] = v * 8 + (s - v); p++; end
        end
    endtask

    task automatic model_accept(input logic [15:0] d, input logic u, input logic l);
        if (u) m_idx = 0;
        blk[m_idx] = d;
        if (m_idx == 0) blk_user = u;
        if (m_idx == 63) begin
            blk_last = l;
            for (int p = 0; p < 64; p++)
                exp_q.push_back({(p == 0) && blk_user, (p == 63) && blk_last, ref_quant(blk[zz[p]], zz[p])});
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- output monitor ----------------
    int hs_total = 0;
    int mark_count = -1;
    int mark_cyc = -1;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_beat;
    logic [17:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                assert ({m_tvalid, m_tuser, m_tlast, m_tdata} === {1'b1, prev_beat}) else begin
                    failures++;
                    $error("FAIL hold_stable got=%h exp=%h", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, prev_beat});
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $error("FAIL extra_output got=%h exp=none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    assert ({m_tuser, m_tlast, m_tdata} === e) else begin
                        failures++;
                        $error("FAIL out_beat got=%h exp=%h", {m_tuser, m_tlast, m_tdata}, e);
                    end
                end
                hs_total++;
                if (hs_total == mark_count) mark_cyc = cyc + 1;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tuser, m_tlast, m_tdata};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
        int waitc = 0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && waitc < 2000) begin
            waitc++;
            @(negedge clk);
        end
        chk("accept_wait", 32'(s_tready), 32'd1);
        if (s_tready) model_accept(d, u, l);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_block(input logic u0, input logic l63, input int gap_max);
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            send_beat(stim[i], u0 && i == 0, l63 && i == 63);
        end
    endtask

    task automatic fill_random(input int mode);
        for (int i = 0; i < 64; i++) begin
            if (mode == 0) stim[i] = 16'($urandom);
            else           stim[i] = 16'(int'($urandom_range(0, 4000)) - 2000);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_latency();
        chk("lat_edge_n", 32'(m_tvalid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge_n1", 32'(m_tvalid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge_n2", 32'(m_tvalid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd1);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_m_tdata"},  32'(m_tdata),  32'd0);
        chk({tag, "_m_tlast"},  32'(m_tlast),  32'd0);
        chk({tag, "_m_tuser"},  32'(m_tuser),  32'd0);
    endtask

    task automatic do_reset(input string tag);
        s_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        m_idx = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    logic rand_done = 1'b0;
    int   waitc;

    initial begin
        build_tables();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_init");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Index 0 = +40 / -40 against Q=16.
        fill_random(1);
        stim[0] = 16'd40;
        send_block(1'b0, 1'b0, 0);
        check_latency();
        wait_drain();
        fill_random(1);
        stim[0] = 16'hFFD8;
        send_block(1'b0, 1'b0, 0);
        wait_drain();

        // Raster index i carries Q[i]*(i+1).
        for (int i = 0; i < 64; i++) stim[i] = 16'(qtab[i] * (i + 1));
        send_block(1'b0, 1'b0, 0);
        wait_drain();

        // Saturation at both extremes.
        fill_random(0);
        stim[0] = 16'h7FFF;
        send_block(1'b0, 1'b0, 0);
        fill_random(0);
        stim[0] = 16'h8000;
        send_block(1'b0, 1'b0, 0);
        wait_drain();

        // Back-to-back blocks, downstream stalls 10 cycles during block 0 drain.
        mark_count = hs_total + 64;
        fork
            begin
                fill_random(1);
                send_block(1'b0, 1'b0, 0);
                fill_random(0);
                send_block(1'b0, 1'b0, 0);
            end
            begin
                waitc = 0;
                while (hs_total < mark_count - 44 && waitc < 500) begin waitc++; @(negedge clk); end
                @(posedge clk); #1;
                m_tready = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
            begin
                int w = 0;
                @(negedge clk);
                while (s_tready && w < 500) begin w++; @(negedge clk); end
                chk("both_full_tready_low", 32'(s_tready), 32'd0);
                w = 0;
                while (!s_tready && w < 500) begin w++; @(negedge clk); end
                chk("tready_rise_cycle", 32'(cyc), 32'(mark_cyc));
            end
        join
        wait_drain();

        // Frame markers, then resync at beat 20.
        fill_random(1);
        send_block(1'b1, 1'b1, 1);
        wait_drain();
        for (int i = 0; i < 84; i++)
            send_beat(16'(int'($urandom_range(0, 4000)) - 2000), i == 0 || i == 20, i == 83);
        wait_drain();

        // Random traffic with random downstream back-pressure.
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    fill_random(b % 2);
                    send_block(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    m_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_tready = 1'b1;
        wait_drain();

        // Reset in the middle of a fill.
        fill_random(1);
        for (int i = 0; i < 30; i++) send_beat(stim[i], i == 0, 1'b0);
        do_reset("reset_fill");

        // Reset in the middle of a drain.
        m_tready = 1'b0;
        fill_random(1);
        stim[0] = 16'd1000;
        send_block(1'b0, 1'b0, 0);
        repeat (3) begin @(posedge clk); #1; end
        m_tready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        do_reset("reset_drain");

        // Clean block after reset.
        fill_random(1);
        send_block(1'b1, 1'b1, 0);
        check_latency();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
